timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- Shares the single countdown Timer (and its load/start path) between two requesters.
  - Requester A: anti-theft FSM (arming delays, alarm duration). High priority.
  - Requester B: fuel-pump hidden-switch window. Low priority.
- Sits between the requesters and the Timer. Owns the Timer's start pulse and load value, and routes expiry back to the current owner as a done pulse.
- A can preempt B; B is never allowed to preempt A.

Parameters:
- TW, 4, width of time values and of the Timer load/count path.

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- req_a  in  1  A request; level, held until done_a or abandoned
- val_a  in  TW  A duration in seconds; sampled at grant
- req_b  in  1  B request; level
- val_b  in  TW  B duration in seconds; sampled at grant
- expired  in  1  Timer expiry flag (level)
- gnt_a  out  1  A owns the Timer
- gnt_b  out  1  B owns the Timer
- done_a  out  1  1-cycle pulse: A's interval elapsed
- done_b  out  1  1-cycle pulse: B's interval elapsed
- preempt_b  out  1  1-cycle pulse: B's interval cancelled by A
- start_timer  out  1  1-cycle reload pulse to Timer
- load_value  out  TW  value presented to Timer; stable from start_timer until next grant
- busy  out  1  state not IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - All outputs go to 0, including load_value = 0.
  - Owner register is cleared.
  - Mid-interval reset discards ownership. No done or preempt pulse is issued.
- States: IDLE, LOAD, SETTLE, RUN, DONE, RELEASE. Owner register: NONE, A or B.
- IDLE:
  - If req_a=1: owner becomes A. Otherwise if req_b=1: owner becomes B.
  - On either grant: latch val_x into load_value and go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - start_timer=1 for exactly this cycle.
  - gnt_x is asserted from this cycle onward.
  - If the latched value is 0: go directly to DONE (Timer result ignored). Otherwise go to SETTLE.
- SETTLE:
  - Single cycle. expired is ignored, to mask a stale flag from the previous interval.
  - Next state is RUN.
- RUN: waits for expired=1, then goes to DONE.
- DONE:
  - done_x=1 for exactly this cycle; gnt_x drops at the end of this cycle.
  - Next state is RELEASE.
- RELEASE:
  - Waits for the finished owner's req to be 0, then goes to IDLE and clears owner.
  - A fresh grant needs req low for at least one cycle.
- Preemption:
  - Trigger: owner=B, req_a=1, state in {LOAD, SETTLE, RUN}.
  - preempt_b pulses for 1 cycle and gnt_b drops.
  - In the same cycle, owner becomes A, val_a is latched, and the next state is LOAD (the Timer is reloaded).
  - No done_b is issued.
- Preemption from B's RELEASE state: a req_a=1 goes straight to LOAD for A with no preempt_b pulse, since B has already completed.
- Abandon:
  - Trigger: the owner's req drops during SETTLE or RUN.
  - Go to IDLE the next cycle with no done pulse and gnt cleared. The Timer is left running; its expiry is ignored.
- Simultaneous events:
  - req_a and req_b asserted together in IDLE: A wins.
  - expired=1 and a preempting req_a in RUN: the preemption wins and no done_b is issued.
- Other rules:
  - gnt_a and gnt_b are never both 1.
  - done_x only pulses while gnt_x=1.
- Latency: req to start_timer is 1 cycle; expired to done_x is 1 cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, SETTLE, RUN, DONE, RELEASE)
  - the owner enum (NONE, A, B)
  - TW default = 4
- No sub-module. This is a single FSM plus the load_value register.

Test Plan:
- Basic B cycle. Stimulus: reset, then req_b=1, val_b=5.
  - Required: start_timer pulses one cycle after req_b with load_value=5, and gnt_b=1.
  - Drive expired=1: done_b pulses 1 cycle later.
  - Hold req_b high for 3 more cycles: no second start_timer until req_b has been low for 1 cycle.
- Priority. Stimulus: req_a and req_b both rise in the same cycle, val_a=3, val_b=9.
  - Required: gnt_a=1 with load_value=3, gnt_b=0.
  - After done_a and req_a dropping: B is granted with load_value=9.
- Preemption. Stimulus: B in RUN with load_value=7, then req_a=1, val_a=2.
  - Required: preempt_b pulses, gnt_b falls, and the next cycle start_timer=1 with load_value=2 and gnt_a=1.
  - done_b is never asserted.
- Stale expiry and zero value.
  - Stale expiry: expired held at 1 across LOAD/SETTLE. Required: no done during SETTLE; done appears in the first RUN cycle + 1.
  - Zero value: val_a=0. Required: done_a two cycles after grant, regardless of expired.
- Abandon and reset.
  - Abandon: req_b drops during RUN. Required: busy=0 next cycle, no done_b.
  - Reset: rst=1 during A's RUN. Required: all outputs 0 next posedge, and no pulses afterwards until a new request.

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// Shared types for the timer arbiter: FSM state and Timer owner encodings.
package timer_arbiter_pkg;

  localparam int unsigned TW_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DONE,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

endpackage

// File: rtl/timer_arbiter.sv
// Shares one countdown Timer between a high-priority (A) and low-priority (B) requester.
// A may preempt B; expiry is routed back to the current owner as a done pulse.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned TW = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [TW-1:0] val_a,
  input  logic          req_b,
  input  logic [TW-1:0] val_b,
  input  logic          expired,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          done_a,
  output logic          done_b,
  output logic          preempt_b,
  output logic          start_timer,
  output logic [TW-1:0] load_value,
  output logic          busy
);

  state_t        state, state_n;
  owner_t        owner, owner_n;
  logic [TW-1:0] load_n;
  logic          take_a, take_b, preempt_n;
  logic          owner_req, a_over_b, active_n;
  logic          gnt_a_n, gnt_b_n, done_a_n, done_b_n, start_n, busy_n;

  // State and every output are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_NONE;
      load_value  <= '0;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      done_a      <= 1'b0;
      done_b      <= 1'b0;
      preempt_b   <= 1'b0;
      start_timer <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      load_value  <= load_n;
      gnt_a       <= gnt_a_n;
      gnt_b       <= gnt_b_n;
      done_a      <= done_a_n;
      done_b      <= done_b_n;
      preempt_b   <= preempt_n;
      start_timer <= start_n;
      busy        <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    load_n    = load_value;
    take_a    = 1'b0;
    take_b    = 1'b0;
    preempt_n = 1'b0;
    owner_req = (owner == OWN_A) ? req_a : ((owner == OWN_B) ? req_b : 1'b0);
    a_over_b  = (owner == OWN_B) && req_a;

    case (state)
      ST_IDLE: begin
        if (req_a)      take_a = 1'b1;
        else if (req_b) take_b = 1'b1;
      end
      ST_LOAD: begin
        if (a_over_b) begin
          take_a    = 1'b1;
          preempt_n = 1'b1;
        end else if (load_value == '0) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_SETTLE;
        end
      end
      // expired is deliberately ignored here: it may still be high from the last interval
      ST_SETTLE: begin
        if (a_over_b) begin
          take_a    = 1'b1;
          preempt_n = 1'b1;
        end else if (!owner_req) begin
          state_n = ST_IDLE;
          owner_n = OWN_NONE;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (a_over_b) begin
          take_a    = 1'b1;
          preempt_n = 1'b1;
        end else if (!owner_req) begin
          state_n = ST_IDLE;
          owner_n = OWN_NONE;
        end else if (expired) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_RELEASE;
      // B has already completed, so A takes over without a preempt pulse
      ST_RELEASE: begin
        if (a_over_b) begin
          take_a = 1'b1;
        end else if (!owner_req) begin
          state_n = ST_IDLE;
          owner_n = OWN_NONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        owner_n = OWN_NONE;
      end
    endcase

    if (take_a) begin
      state_n = ST_LOAD;
      owner_n = OWN_A;
      load_n  = val_a;
    end else if (take_b) begin
      state_n = ST_LOAD;
      owner_n = OWN_B;
      load_n  = val_b;
    end

    active_n = (state_n == ST_LOAD) || (state_n == ST_SETTLE) ||
               (state_n == ST_RUN)  || (state_n == ST_DONE);
    gnt_a_n  = active_n && (owner_n == OWN_A);
    gnt_b_n  = active_n && (owner_n == OWN_B);
    done_a_n = (state_n == ST_DONE) && (owner_n == OWN_A);
    done_b_n = (state_n == ST_DONE) && (owner_n == OWN_B);
    start_n  = (state_n == ST_LOAD);
    busy_n   = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: directed test-plan scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_timer_arbiter;

  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst, req_a, req_b, expired;
  logic [TW-1:0] val_a, val_b;
  logic          gnt_a, gnt_b, done_a, done_b, preempt_b, start_timer, busy;
  logic [TW-1:0] load_value;

  int n_total = 0;
  int n_bad   = 0;

  // Model: owner 0/1/2 = none/A/B; phase 0 idle, 1 interval, 2 done, 3 release.
  // age counts cycles since the Timer load: 0 load, 1 settle, 2 running.
  int            m_own, m_phase, m_age;
  logic [TW-1:0] m_lv;
  logic          m_pre;

  timer_arbiter #(.TW(TW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .val_a(val_a), .req_b(req_b), .val_b(val_b),
    .expired(expired),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .preempt_b(preempt_b), .start_timer(start_timer),
    .load_value(load_value), .busy(busy)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic grant_a();
    m_own   = 1;
    m_lv    = val_a;
    m_phase = 1;
    m_age   = 0;
  endtask

  task automatic model_step();
    logic myreq;
    myreq = (m_own == 1) ? req_a : ((m_own == 2) ? req_b : 1'b0);
    m_pre = 1'b0;
    if (rst) begin
      m_own = 0; m_phase = 0; m_age = 0; m_lv = '0;
    end else begin
      case (m_phase)
        0: begin
          if (req_a) grant_a();
          else if (req_b) begin
            m_own = 2; m_lv = val_b; m_phase = 1; m_age = 0;
          end
        end
        1: begin
          if (m_own == 2 && req_a) begin
            grant_a();
            m_pre = 1'b1;
          end else if (m_age == 0) begin
            if (m_lv == 0) m_phase = 2;
            else m_age = 1;
          end else if (!myreq) begin
            m_phase = 0; m_own = 0;
          end else if (m_age >= 2 && expired) begin
            m_phase = 2;
          end else begin
            m_age = 2;
          end
        end
        2: m_phase = 3;
        default: begin
          if (m_own == 2 && req_a) grant_a();
          else if (!myreq) begin
            m_phase = 0; m_own = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare every output just after.
  task automatic cyc(input int r, input int ra, input int va, input int rb, input int vb,
                     input int ex);
    logic act;
    rst = 1'(r); req_a = 1'(ra); val_a = TW'(va); req_b = 1'(rb); val_b = TW'(vb);
    expired = 1'(ex);
    @(posedge clk);
    model_step();
    #1;
    act = (m_phase == 1) || (m_phase == 2);
    check("gnt_a",       16'(gnt_a),       16'(act && m_own == 1));
    check("gnt_b",       16'(gnt_b),       16'(act && m_own == 2));
    check("done_a",      16'(done_a),      16'(m_phase == 2 && m_own == 1));
    check("done_b",      16'(done_b),      16'(m_phase == 2 && m_own == 2));
    check("preempt_b",   16'(preempt_b),   16'(m_pre));
    check("start_timer", 16'(start_timer), 16'(m_phase == 1 && m_age == 0));
    check("load_value",  16'(load_value),  16'(m_lv));
    check("busy",        16'(busy),        16'(m_phase != 0));
    check("gnt_excl",    16'(gnt_a && gnt_b), 16'(0));
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ra_l, rb_l, done_b_seen;
    m_own = 0; m_phase = 0; m_age = 0; m_lv = '0; m_pre = 1'b0;

    // reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 7, 1, 7, 1);
    check("rst_load", 16'(load_value), 16'(0));
    check("rst_busy", 16'(busy), 16'(0));

    // basic B cycle
    cyc(0, 0, 0, 1, 5, 0);
    check("b_start", 16'(start_timer), 16'(1));
    check("b_load",  16'(load_value),  16'(5));
    check("b_gnt",   16'(gnt_b),       16'(1));
    cyc(0, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 1, 5, 1);
    check("b_done", 16'(done_b), 16'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 5, 0);
      check("b_no_restart", 16'(start_timer), 16'(0));
    end
    cyc(0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 1, 5, 0);
    check("b_regrant", 16'(start_timer), 16'(1));
    quiet(2);

    // priority: A and B together
    cyc(0, 1, 3, 1, 9, 0);
    check("prio_gnt_a", 16'(gnt_a), 16'(1));
    check("prio_gnt_b", 16'(gnt_b), 16'(0));
    check("prio_load",  16'(load_value), 16'(3));
    cyc(0, 1, 3, 1, 9, 0);
    cyc(0, 1, 3, 1, 9, 0);
    cyc(0, 1, 3, 1, 9, 1);
    check("prio_done_a", 16'(done_a), 16'(1));
    cyc(0, 0, 3, 1, 9, 0);
    cyc(0, 0, 3, 1, 9, 0);
    cyc(0, 0, 3, 1, 9, 0);
    check("prio_b_gnt",  16'(gnt_b), 16'(1));
    check("prio_b_load", 16'(load_value), 16'(9));
    quiet(3);

    // preemption of B in RUN
    done_b_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 7, 0);
      done_b_seen += int'(done_b);
    end
    cyc(0, 1, 2, 1, 7, 1);
    check("pre_pulse", 16'(preempt_b), 16'(1));
    check("pre_gnt_b", 16'(gnt_b), 16'(0));
    check("pre_start", 16'(start_timer), 16'(1));
    check("pre_load",  16'(load_value), 16'(2));
    check("pre_gnt_a", 16'(gnt_a), 16'(1));
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 2, 1, 7, 1);
      done_b_seen += int'(done_b);
    end
    check("pre_no_done_b", 16'(done_b_seen), 16'(0));
    quiet(3);

    // stale expiry held through LOAD/SETTLE
    cyc(0, 1, 4, 0, 0, 1);
    cyc(0, 1, 4, 0, 0, 1);
    check("stale_settle", 16'(done_a), 16'(0));
    cyc(0, 1, 4, 0, 0, 1);
    check("stale_run", 16'(done_a), 16'(0));
    cyc(0, 1, 4, 0, 0, 1);
    check("stale_done", 16'(done_a), 16'(1));
    quiet(2);

    // zero value finishes without the Timer
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("zero_done", 16'(done_a), 16'(1));
    quiet(2);

    // abandon during RUN
    cyc(0, 0, 0, 1, 6, 0);
    cyc(0, 0, 0, 1, 6, 0);
    cyc(0, 0, 0, 1, 6, 0);
    cyc(0, 0, 0, 0, 6, 1);
    check("abandon_busy", 16'(busy), 16'(0));
    check("abandon_done", 16'(done_b), 16'(0));
    quiet(2);

    // reset during A's RUN
    cyc(0, 1, 8, 0, 0, 0);
    cyc(0, 1, 8, 0, 0, 0);
    cyc(0, 1, 8, 0, 0, 0);
    cyc(1, 1, 8, 0, 0, 1);
    check("rst_mid_gnt",  16'(gnt_a), 16'(0));
    check("rst_mid_load", 16'(load_value), 16'(0));
    for (int i = 0; i < 3; i++) cyc(0, 0, 8, 0, 0, 1);
    check("rst_mid_quiet", 16'({done_a, done_b, start_timer, busy}), 16'(0));

    // randomized traffic
    ra_l = 0; rb_l = 0;
    for (int i = 0; i < 4000; i++) begin
      int va, vb;
      if ($urandom_range(0, 7) == 0) ra_l = 1 - ra_l;
      if ($urandom_range(0, 5) == 0) rb_l = 1 - rb_l;
      va = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      vb = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      cyc(($urandom_range(0, 199) == 0) ? 1 : 0, ra_l, va, rb_l, vb,
          ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
